score_window_loader: RTL
========================

# score_window_loader

Parametrised successor to the fixed 16-note score loader. It plays a note stream from an external synchronous score ROM into a shift window of upcoming notes, one note per tempo beat, for the video display and scoring logic. Compared with the fixed loader it adds configurable note width, window depth and done-tap, a tempo period set at run time, explicit start/pause control, optional looping, and an implicit end when the ROM address wraps.

## Interface

Parameters:
- NOTE_W, 4: bits per note code.
- WINDOW, 16: number of window slots (≥ 2).
- ADDR_W, 8: score ROM address width.
- DONE_TAP, 7: slot whose END code raises song_done (0 ≤ DONE_TAP < WINDOW).
- REST, 0: rest code.
- END, all-ones: end-of-song code.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: 1-cycle pulse that (re)starts playback.
- song_id, in, 2: song select, latched on start.
- beat_period, in, 26: clocks per beat, latched on start. Values below 2 are treated as 2.
- pause, in, 1: level; while high, freezes the tempo counter and the window.
- loop_en, in, 1: level, sampled at each beat. Selects looping instead of ending.
- rom_song, out, 2: latched song_id.
- rom_addr, out, ADDR_W: score ROM address.
- rom_data, in, NOTE_W: ROM word, valid one clock after rom_addr/rom_song change.
- next_notes_out, out, WINDOW*NOTE_W: slot i is bits [i*NOTE_W +: NOTE_W]. Slot 0 is the current note; slot WINDOW-1 is the newest note.
- beat, out, 1: 1-cycle pulse on every window shift.
- busy, out, 1: high in PLAY and DRAIN.
- song_done, out, 1: sticky end flag.
- loop_count, out, 8: completed loops, saturating at 255.

## Operation

State machine: IDLE, PLAY, DRAIN.

Reset values: state IDLE; every window slot REST; rom_addr 0; rom_song 0; beat 0; busy 0; song_done 0; loop_count 0; tempo counter 0.

Tempo counter:
- Counts 0 to P-1, where P is the latched period. A beat fires when the counter equals P-1; the counter then returns to 0.
- The counter runs only in PLAY or DRAIN and only while pause is low.

start, accepted in any state (mid-song start is a clean restart):
- Latch song_id and P.
- Clear the window to REST.
- rom_addr ← 0, counter ← 0, song_done ← 0, loop_count ← 0.
- Go to PLAY.

Every beat shifts the window down: slot i ← slot i+1.

Beat in PLAY (let D = rom_data):
- D ≠ END: slot WINDOW-1 ← D, then rom_addr+1. If rom_addr was all-ones, the next beat treats the word as END (implicit end).
- D == END and loop_en = 1: slot WINDOW-1 ← REST, rom_addr ← 0, loop_count+1. Looping leaves a deliberate one-beat rest gap between passes.
- D == END and loop_en = 0: slot WINDOW-1 ← END, go to DRAIN, and rom_addr holds.

Beat in DRAIN:
- Slot WINDOW-1 ← REST.
- If END is shifted into DONE_TAP, song_done ← 1 on the same edge.
- If END is shifted out of slot 0, go to IDLE.

In IDLE no beats occur, and the window and song_done hold.

## Timing

- Start edge at cycle 0: window cleared, PLAY and counter 0 at cycle 1.
- First beat at cycle P: note 0 enters slot WINDOW-1.
- Note k reaches slot 0 on beat k+WINDOW.
- rom_addr is registered. With P ≥ 2, rom_data is always settled by the next beat.
- beat, next_notes_out, song_done and busy all change on the same edge.
- pause asserted on a beat cycle suppresses that beat; the counter resumes from its held value.
- start and beat in the same cycle: start wins and no shift occurs.
- Asynchronous reset in mid-song forces the reset values immediately, with no drain.

## Test plan

- Reset during PLAY with window non-empty → all outputs at reset values within the same cycle; a subsequent start replays from address 0.
- ROM {1,2,3,END}, P=4, WINDOW=16, DONE_TAP=7, loop_en=0 → beats every 4 clocks; after beat 3, top slots read 3,2,1; END enters slot 15 on beat 4; song_done rises on beat 12; IDLE after beat 20.
- Same ROM, loop_en=1 → sequence 1,2,3,REST,1,2,3,REST…; loop_count increments on each END fetch; song_done is never asserted.
- pause held 10 clocks mid-song with P=4 → no beat and no window change during pause; beat spacing resumes exactly from the held counter.
- ROM with no END over 256 words, ADDR_W=8 → word 255 is played, then the implicit END is taken and the normal drain and song_done follow.
- beat_period=0 → behaves as P=2; start asserted on the same cycle as a beat → no shift, window cleared, first new beat 2 clocks later.

Source files
------------

// File: rtl/score_window_loader.sv
// Plays a note stream from a synchronous score ROM into a shift window of
// upcoming notes, one note per tempo beat, with start/pause/loop control.
module score_window_loader #(
   parameter int                NOTE_W   = 4,
   parameter int                WINDOW   = 16,
   parameter int                ADDR_W   = 8,
   parameter int                DONE_TAP = 7,
   parameter logic [NOTE_W-1:0] REST     = '0,
   parameter logic [NOTE_W-1:0] END      = '1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [1:0]                 song_id,
   input  logic [25:0]                beat_period,
   input  logic                       pause,
   input  logic                       loop_en,
   output logic [1:0]                 rom_song,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [NOTE_W-1:0]          rom_data,
   output logic [WINDOW*NOTE_W-1:0]   next_notes_out,
   output logic                       beat,
   output logic                       busy,
   output logic                       song_done,
   output logic [7:0]                 loop_count
);

   typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

   state_t            state;
   logic [25:0]       period;
   logic [25:0]       cnt;
   logic              wrap_end;
   logic              fetch_end;
   logic              tick;
   logic [NOTE_W-1:0] win    [WINDOW];
   logic [NOTE_W-1:0] win_sh [WINDOW];

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [25:0] clamp_period(input logic [25:0] p);
      return (p < 26'd2) ? 26'd2 : p;
   endfunction

   // A wrapped address counts as END even though the ROM word itself is not.
   assign fetch_end = wrap_end || (rom_data == END);
   assign tick      = (state != IDLE) && !pause && (cnt == period - 26'd1);

   always_comb begin
      for (int i = 0; i < WINDOW-1; i++)
         win_sh[i] = win[i+1];
      if (state == PLAY && !fetch_end)
         win_sh[WINDOW-1] = rom_data;
      else if (state == PLAY && !loop_en)
         win_sh[WINDOW-1] = END;
      else
         win_sh[WINDOW-1] = REST;
   end

   for (genvar g = 0; g < WINDOW; g++) begin : g_pack
      assign next_notes_out[g*NOTE_W +: NOTE_W] = win[g];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         for (int i = 0; i < WINDOW; i++)
            win[i] <= REST;
         rom_addr   <= '0;
         rom_song   <= '0;
         period     <= 26'd2;
         cnt        <= '0;
         wrap_end   <= 1'b0;
         beat       <= 1'b0;
         busy       <= 1'b0;
         song_done  <= 1'b0;
         loop_count <= '0;
      end else begin
         beat <= 1'b0;
         if (start) begin
            // Start overrides any beat due on the same edge.
            rom_song   <= song_id;
            period     <= clamp_period(beat_period);
            for (int i = 0; i < WINDOW; i++)
               win[i] <= REST;
            rom_addr   <= '0;
            cnt        <= '0;
            wrap_end   <= 1'b0;
            song_done  <= 1'b0;
            loop_count <= '0;
            state      <= PLAY;
            busy       <= 1'b1;
         end else if (tick) begin
            cnt  <= '0;
            beat <= 1'b1;
            for (int i = 0; i < WINDOW; i++)
               win[i] <= win_sh[i];
            if (win_sh[DONE_TAP] == END)
               song_done <= 1'b1;
            case (state)
               PLAY: begin
                  if (!fetch_end) begin
                     rom_addr <= rom_addr + ADDR_W'(1);
                     wrap_end <= &rom_addr;
                  end else if (loop_en) begin
                     rom_addr   <= '0;
                     wrap_end   <= 1'b0;
                     loop_count <= sat_inc8(loop_count);
                  end else begin
                     state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (win[0] == END) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end else if (state != IDLE && !pause) begin
            cnt <= cnt + 26'd1;
         end
      end
   end

endmodule
